// File: rtl/phase_bank.sv
// Double-buffered phase/pwm_en register bank for all transducer channels.
// Command words land in a shadow copy; COMMIT moves shadow to active, optionally on a PWM period boundary.
module phase_bank #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned PHASE_WIDTH  = 8,
  parameter int unsigned SYNC_COMMIT  = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [31:0]                         in_data,
  input  logic                                period_sync,
  output logic [NUM_CHANNELS*PHASE_WIDTH-1:0] phases,
  output logic [NUM_CHANNELS-1:0]             pwm_ens,
  output logic                                commit_done,
  output logic [7:0]                          err_count
);

  localparam int unsigned BANK_W = NUM_CHANNELS * PHASE_WIDTH;

  localparam logic [7:0] OP_WRITE  = 8'h00;
  localparam logic [7:0] OP_BCAST  = 8'h01;
  localparam logic [7:0] OP_COMMIT = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    APPLY     = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [BANK_W-1:0]        shadow_ph_q, shadow_ph_d;
  logic [NUM_CHANNELS-1:0]  shadow_en_q, shadow_en_d;
  logic [7:0]               err_q, err_d;
  logic                     ready_q, ready_d;
  logic [BANK_W-1:0]        phases_q;
  logic [NUM_CHANNELS-1:0]  pwm_ens_q;
  logic                     done_q;
  logic                     apply_c;
  logic                     accept_c;

  logic [7:0]             opcode;
  logic [7:0]             addr;
  logic [PHASE_WIDTH-1:0] phase_val;
  logic                   en_val;
  logic                   addr_ok;
  logic                   unused_bits;

  assign opcode      = in_data[31:24];
  assign en_val      = in_data[16];
  assign addr        = in_data[15:8];
  assign phase_val   = in_data[PHASE_WIDTH-1:0];
  assign addr_ok     = {1'b0, addr} < 9'(NUM_CHANNELS);
  assign unused_bits = ^{in_data[23:17], in_data[7:0]};
  assign accept_c    = in_valid && ready_q;

  // Next-state, shadow update and error accounting
  always_comb begin
    state_d     = state_q;
    shadow_ph_d = shadow_ph_q;
    shadow_en_d = shadow_en_q;
    err_d       = err_q;
    apply_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          unique case (opcode)
            OP_WRITE: begin
              if (addr_ok) begin
                for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                  if (addr == 8'(i)) begin
                    shadow_ph_d[i*PHASE_WIDTH +: PHASE_WIDTH] = phase_val;
                    shadow_en_d[i]                            = en_val;
                  end
                end
              end else if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
              end
            end
            OP_BCAST: begin
              for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                shadow_ph_d[i*PHASE_WIDTH +: PHASE_WIDTH] = phase_val;
                shadow_en_d[i]                            = en_val;
              end
            end
            OP_COMMIT: state_d = (SYNC_COMMIT != 0) ? WAIT_SYNC : APPLY;
            OP_CLEAR: begin
              shadow_ph_d = '0;
              shadow_en_d = '0;
            end
            default: begin
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
          endcase
        end
      end
      WAIT_SYNC: begin
        if (period_sync) state_d = APPLY;
      end
      APPLY: begin
        apply_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_ph_q <= '0;
      shadow_en_q <= '0;
      err_q       <= '0;
      ready_q     <= 1'b0;
      phases_q    <= '0;
      pwm_ens_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_ph_q <= shadow_ph_d;
      shadow_en_q <= shadow_en_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      done_q      <= apply_c;
      if (apply_c) begin
        phases_q  <= shadow_ph_q;
        pwm_ens_q <= shadow_en_q;
      end
    end
  end

  assign in_ready    = ready_q;
  assign phases      = phases_q;
  assign pwm_ens     = pwm_ens_q;
  assign commit_done = done_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_phase_bank.sv
// Randomised bench for phase_bank: instance 0 commits on period_sync, instance 1 commits immediately.
module tb_phase_bank;

  localparam int unsigned NCH = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid    [2];
  logic [31:0]       in_data     [2];
  logic              period_sync [2];
  logic              in_ready    [2];
  logic [NCH*8-1:0]  phases      [2];
  logic [NCH-1:0]    pwm_ens     [2];
  logic              commit_done [2];
  logic [7:0]        err_count   [2];

  int vectors;
  int miscompares;

  int sh_ph [2][NCH];
  int sh_en [2][NCH];
  int ac_ph [2][NCH];
  int ac_en [2][NCH];
  int err   [2];

  phase_bank #(.NUM_CHANNELS(NCH), .PHASE_WIDTH(8), .SYNC_COMMIT(1)) u_sync (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .period_sync(period_sync[0]), .phases(phases[0]),
    .pwm_ens(pwm_ens[0]), .commit_done(commit_done[0]), .err_count(err_count[0])
  );

  phase_bank #(.NUM_CHANNELS(NCH), .PHASE_WIDTH(8), .SYNC_COMMIT(0)) u_async (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .period_sync(period_sync[1]), .phases(phases[1]),
    .pwm_ens(pwm_ens[1]), .commit_done(commit_done[1]), .err_count(err_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The immediate-commit instance sees random sync noise that it must ignore
  initial begin
    period_sync[1] = 1'b0;
    forever begin
      @(negedge clk);
      period_sync[1] = 1'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_active(input int d, input string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      check({tag, "_ph"}, 32'(phases[d][ch*8 +: 8]), 32'(ac_ph[d][ch]));
      check({tag, "_en"}, 32'(pwm_ens[d][ch]), 32'(ac_en[d][ch]));
    end
    check({tag, "_err"}, 32'(err_count[d]), 32'(err[d]));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      err[d] = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        sh_ph[d][ch] = 0; sh_en[d][ch] = 0; ac_ph[d][ch] = 0; ac_en[d][ch] = 0;
      end
    end
  endtask

  task automatic model_word(input int d, input logic [31:0] w);
    int op, en, addr, ph;
    op = int'(w[31:24]); en = int'(w[16]); addr = int'(w[15:8]); ph = int'(w[7:0]);
    if (op == 0) begin
      if (addr < NCH) begin sh_ph[d][addr] = ph; sh_en[d][addr] = en; end
      else if (err[d] < 255) err[d]++;
    end else if (op == 1) begin
      for (int ch = 0; ch < NCH; ch++) begin sh_ph[d][ch] = ph; sh_en[d][ch] = en; end
    end else if (op == 3) begin
      for (int ch = 0; ch < NCH; ch++) begin sh_ph[d][ch] = 0; sh_en[d][ch] = 0; end
    end else if (op != 2) begin
      if (err[d] < 255) err[d]++;
    end
  endtask

  task automatic model_commit(input int d);
    for (int ch = 0; ch < NCH; ch++) begin
      ac_ph[d][ch] = sh_ph[d][ch]; ac_en[d][ch] = sh_en[d][ch];
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance
  task automatic send(input int d, input logic [31:0] w);
    int n;
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      check("ready_timeout", 32'(in_ready[d]), 32'd1);
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    model_word(d, w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(in_ready[d]), 32'd0);
      check("rst_done", 32'(commit_done[d]), 32'd0);
      check_active(d, "rst");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("rst_ready_rel", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic commit_sync(input int delay, input bit coincide);
    period_sync[0] = coincide;
    send(0, 32'h0200_0000);
    period_sync[0] = 1'b0;
    for (int i = 0; i < delay; i++) begin
      check("ws_ready", 32'(in_ready[0]), 32'd0);
      check("ws_done", 32'(commit_done[0]), 32'd0);
      check_active(0, "ws");
      @(negedge clk);
    end
    period_sync[0] = 1'b1;
    @(negedge clk);
    period_sync[0] = 1'b0;
    check("ap_ready", 32'(in_ready[0]), 32'd0);
    check("ap_done", 32'(commit_done[0]), 32'd0);
    check_active(0, "ap_old");
    @(negedge clk);
    model_commit(0);
    check("cs_done", 32'(commit_done[0]), 32'd1);
    check("cs_ready", 32'(in_ready[0]), 32'd1);
    check_active(0, "cs_new");
    @(negedge clk);
    check("cs_done_end", 32'(commit_done[0]), 32'd0);
  endtask

  task automatic commit_async();
    send(1, 32'h0200_0000);
    check("ca_ready", 32'(in_ready[1]), 32'd0);
    check("ca_done0", 32'(commit_done[1]), 32'd0);
    check_active(1, "ca_old");
    @(negedge clk);
    model_commit(1);
    check("ca_done", 32'(commit_done[1]), 32'd1);
    check("ca_ready_back", 32'(in_ready[1]), 32'd1);
    check_active(1, "ca_new");
    @(negedge clk);
    check("ca_done_end", 32'(commit_done[1]), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = int'($urandom_range(0, 9));
    if (sel <= 3)      w[31:24] = 8'h00;
    else if (sel == 4) w[31:24] = 8'h01;
    else if (sel == 5) w[31:24] = 8'h03;
    else if (sel == 6) w[31:24] = 8'($urandom_range(4, 255));
    else               w[31:24] = 8'h00;
    if (w[31:24] == 8'h00) w[15:8] = 8'($urandom_range(0, (sel <= 3) ? NCH : NCH - 1));
    return w;
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin in_valid[d] = 1'b0; in_data[d] = '0; end
    period_sync[0] = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    do_reset();

    // Writes stay in shadow
    send(0, 32'h0001_0101);
    check_active(0, "t1a");
    send(0, 32'h0000_0202);
    check_active(0, "t1b");
    check("t1_done", 32'(commit_done[0]), 32'd0);

    commit_sync(5, 1'b0);
    check("t2_ph1", 32'(phases[0][15:8]), 32'h01);
    check("t2_ph2", 32'(phases[0][23:16]), 32'h02);
    check("t2_en", 32'(pwm_ens[0]), 32'h2);

    // Broadcast and immediate commit
    send(1, 32'h0101_00A5);
    commit_async();
    check("t3_ph", 32'(phases[1]), 32'hA5A5_A5A5);
    check("t3_en", 32'(pwm_ens[1]), 32'hF);

    // Randomised traffic with periodic commits, including back-to-back words
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        send(d, rand_word());
        check_active(d, "rnd");
        if (i % 8 == 7) begin
          if (d == 0) commit_sync(int'($urandom_range(1, 6)), 1'($urandom));
          else        commit_async();
        end
      end
      if (d == 0) commit_sync(2, 1'b0);
      else        commit_async();
    end

    // Sync on the accepting edge is ignored; repeated commit of unchanged shadow
    send(0, 32'h0001_0377);
    commit_sync(3, 1'b1);
    commit_sync(1, 1'b0);

    // Reset while waiting for sync discards the commit
    send(0, 32'h0101_005A);
    send(0, 32'h0200_0000);
    @(negedge clk);
    do_reset();
    period_sync[0] = 1'b1;
    @(negedge clk);
    period_sync[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_done", 32'(commit_done[0]), 32'd0);
      check("t6_ready", 32'(in_ready[0]), 32'd1);
      check_active(0, "t6");
      @(negedge clk);
    end
    send(0, 32'h0101_0033);
    send(0, 32'h0300_0000);
    commit_sync(2, 1'b0);
    check("t6_zero", 32'(phases[0]), 32'h0);

    // Error counting and saturation
    send(0, {8'h00, 8'h01, 8'(NCH), 8'h44});
    send(0, 32'h7F00_0000);
    check("t4_err2", 32'(err_count[0]), 32'd2);
    commit_sync(1, 1'b0);
    for (int i = 0; i < 300; i++) send(0, {8'($urandom_range(4, 255)), 24'($urandom)});
    check("t4_sat", 32'(err_count[0]), 32'hFF);
    check_active(0, "t4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
